// File: rtl/dmem_arbiter_pkg.sv
// Shared pipeline definitions for the data-memory arbiter: widths, owner and
// read-return state encodings, and the default starvation limit.
package dmem_arbiter_pkg;

    localparam int DATA_W               = 32;
    localparam int ADDR_W               = 32;
    localparam int CNT_W                = 4;
    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CPU  = 2'd1,
        OWNER_EXT  = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_CPU  = 2'd1,
        RD_EXT  = 2'd2
    } rd_state_e;

    // Read-return state implied by the owner granted this cycle and its write strobe.
    function automatic rd_state_e rd_state_for(input owner_e owner, input logic cpu_we,
                                               input logic ext_we);
        rd_state_e st;
        st = RD_IDLE;
        if (owner == OWNER_CPU && !cpu_we) begin
            st = RD_CPU;
        end else if (owner == OWNER_EXT && !ext_we) begin
            st = RD_EXT;
        end
        return st;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the cpu memory stage and an external
// (debug/DMA) port, with cpu priority, ext starvation protection and 1-cycle read return.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT  // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_grant,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,

    output logic [ADDR_W-1:0] mem_idx,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_read_data,

    output rd_state_e         dbg_state,
    output logic [CNT_W-1:0]  dbg_starve_cnt
);

    // Handshake: a request is accepted exactly in the cycle its grant is high
    // (cpu: cpu_req && !cpu_stall, ext: ext_grant); the requester holds its
    // fields until then and nothing is latched here. Read data comes back one
    // cycle after acceptance, flagged by the matching rvalid.

    owner_e          grant_owner;
    logic            starve_at_limit;

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    rd_state_e        state_q, state_d;
    logic             cpu_rvalid_q, cpu_rvalid_d;
    logic             ext_rvalid_q, ext_rvalid_d;

    assign starve_at_limit = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        grant_owner = OWNER_NONE;
        if (!rst) begin
            if (cpu_req && !(ext_req && starve_at_limit)) begin
                grant_owner = OWNER_CPU;
            end else if (ext_req) begin
                grant_owner = OWNER_EXT;
            end
        end
    end

    assign cpu_stall = cpu_req && (grant_owner != OWNER_CPU);
    assign ext_grant = (grant_owner == OWNER_EXT);

    always_comb begin
        mem_idx          = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        case (grant_owner)
            OWNER_CPU: begin
                mem_idx          = cpu_addr;
                mem_write_data   = cpu_wdata;
                mem_write_enable = cpu_we;
            end
            OWNER_EXT: begin
                mem_idx          = ext_addr;
                mem_write_data   = ext_wdata;
                mem_write_enable = ext_we;
            end
            default: begin
                mem_idx          = '0;
                mem_write_data   = '0;
                mem_write_enable = 1'b0;
            end
        endcase
    end

    // Counts cycles ext waits while blocked; saturates so ext wins the next tie.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!ext_req || ext_grant) begin
            starve_cnt_d = '0;
        end else if (!starve_at_limit) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d      = rd_state_for(grant_owner, cpu_we, ext_we);
        cpu_rvalid_d = (state_d == RD_CPU);
        ext_rvalid_d = (state_d == RD_EXT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RD_IDLE;
            starve_cnt_q <= '0;
            cpu_rvalid_q <= 1'b0;
            ext_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            ext_rvalid_q <= ext_rvalid_d;
        end
    end

    // A read in flight when rst rises is dropped immediately, not one cycle later.
    assign cpu_rvalid = cpu_rvalid_q && !rst;
    assign ext_rvalid = ext_rvalid_q && !rst;
    assign cpu_rdata  = cpu_rvalid ? mem_read_data : '0;
    assign ext_rdata  = ext_rvalid ? mem_read_data : '0;

    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (starvation limits 4 and 1) share one
// stimulus stream; each has its own memory and is checked every cycle against a model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_en = 1'b1;
  always #5 clk = ~clk;

  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        ext_req = 1'b0, ext_we = 1'b0;
  logic [31:0] ext_addr = '0, ext_wdata = '0;

  logic        cpu_stall_w [2];
  logic        cpu_rvalid_w[2];
  logic [31:0] cpu_rdata_w [2];
  logic        ext_grant_w [2];
  logic        ext_rvalid_w[2];
  logic [31:0] ext_rdata_w [2];
  logic [31:0] mem_idx_w   [2];
  logic [31:0] mem_wdata_w [2];
  logic        mem_we_w    [2];
  logic [31:0] mem_rdata_w [2];
  rd_state_e   dbg_state_w [2];
  logic [3:0]  dbg_cnt_w   [2];

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return 32'hA500_0000 | (i * 32'h0101);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_arbiter #(.STARVE_LIMIT((g == 0) ? 4 : 1)) u_dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall_w[g]), .cpu_rvalid(cpu_rvalid_w[g]), .cpu_rdata(cpu_rdata_w[g]),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_grant(ext_grant_w[g]), .ext_rvalid(ext_rvalid_w[g]), .ext_rdata(ext_rdata_w[g]),
      .mem_idx(mem_idx_w[g]), .mem_write_data(mem_wdata_w[g]),
      .mem_write_enable(mem_we_w[g]), .mem_read_data(mem_rdata_w[g]),
      .dbg_state(dbg_state_w[g]), .dbg_starve_cnt(dbg_cnt_w[g])
    );
  end

  // Physical single-port memories, one per instance, 1-cycle read latency.
  logic [31:0] phys_mem[2][64];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (load_en) begin
        for (int i = 0; i < 64; i++) phys_mem[k][i] <= init_word(i);
      end else if (mem_we_w[k]) begin
        phys_mem[k][mem_idx_w[k][5:0]] <= mem_wdata_w[k];
      end
      mem_rdata_w[k] <= phys_mem[k][mem_idx_w[k][5:0]];
    end
  end

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Behavioural model: grant rule, waiting-cycle count, pending read, memory contents.
  int          m_cnt [2];
  int          m_pend[2];   // 0 none, 1 cpu read outstanding, 2 ext read outstanding
  logic [31:0] m_pdata[2];
  logic [31:0] ref_mem[2][64];
  logic        last_cpu_gnt = 1'b0, last_ext_gnt = 1'b0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_pend[k] = 0; m_pdata[k] = '0;
      for (int i = 0; i < 64; i++) ref_mem[k][i] = init_word(i);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        automatic int lim = (k == 0) ? 4 : 1;
        automatic logic ec = !rst && cpu_req && !(ext_req && m_cnt[k] == lim);
        automatic logic ee = !rst && ext_req && !ec;
        automatic logic [31:0] e_idx = ec ? cpu_addr : (ee ? ext_addr : 32'h0);
        automatic logic [31:0] e_wd  = ec ? cpu_wdata : (ee ? ext_wdata : 32'h0);
        automatic logic e_we = (ec && cpu_we) || (ee && ext_we);
        automatic logic e_crv = !rst && m_pend[k] == 1;
        automatic logic e_erv = !rst && m_pend[k] == 2;
        check("cpu_stall", k, cpu_stall_w[k], cpu_req && !ec);
        check("ext_grant", k, ext_grant_w[k], ee);
        check("mem_idx", k, mem_idx_w[k], e_idx);
        check("mem_write_data", k, mem_wdata_w[k], e_wd);
        check("mem_write_enable", k, mem_we_w[k], e_we);
        check("cpu_rvalid", k, cpu_rvalid_w[k], e_crv);
        check("cpu_rdata", k, cpu_rdata_w[k], e_crv ? m_pdata[k] : 32'h0);
        check("ext_rvalid", k, ext_rvalid_w[k], e_erv);
        check("ext_rdata", k, ext_rdata_w[k], e_erv ? m_pdata[k] : 32'h0);
        check("starve_cnt", k, dbg_cnt_w[k], m_cnt[k]);
        if (k == 0) begin
          last_cpu_gnt = ec;
          last_ext_gnt = ee;
        end
        if (rst) begin
          m_cnt[k] = 0;
          m_pend[k] = 0;
        end else begin
          m_pend[k]  = (ec && !cpu_we) ? 1 : ((ee && !ext_we) ? 2 : 0);
          m_pdata[k] = ref_mem[k][e_idx[5:0]];
          if (e_we) ref_mem[k][e_idx[5:0]] = e_wd;
          if (!ext_req || ee) m_cnt[k] = 0;
          else if (m_cnt[k] < lim) m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] a,
                         input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_ext(input logic req, input logic we, input logic [31:0] a,
                         input logic [31:0] d);
    ext_req = req; ext_we = we; ext_addr = a; ext_wdata = d;
  endtask

  initial begin
    step();
    chk_en = 1'b1;
    step();
    #2;
    check("reset_state", 0, dbg_state_w[0], RD_IDLE);
    check("reset_cnt", 0, dbg_cnt_w[0], 32'h0);
    check("reset_cpu_rvalid", 0, cpu_rvalid_w[0], 32'h0);
    step();
    load_en = 1'b0;
    rst = 1'b0;
    step();

    // cpu load from 0x10 with ext idle
    set_cpu(1, 0, 32'h10, 0); set_ext(0, 0, 0, 0);
    #2 check("r29_stall", 0, cpu_stall_w[0], 32'h0);
    step();
    set_cpu(0, 0, 0, 0);
    #2;
    check("r29_rvalid", 0, cpu_rvalid_w[0], 32'h1);
    check("r29_rdata", 0, cpu_rdata_w[0], 32'hDEADBEEF);
    check("r29_ext_rvalid", 0, ext_rvalid_w[0], 32'h0);

    // cpu store then ext load of the same word
    set_cpu(1, 1, 32'h20, 32'h55);
    step();
    set_cpu(0, 0, 0, 0); set_ext(1, 0, 32'h20, 0);
    step();
    set_ext(0, 0, 0, 0);
    #2;
    check("r31_ext_rvalid", 0, ext_rvalid_w[0], 32'h1);
    check("r31_ext_rdata", 0, ext_rdata_w[0], 32'h55);
    check("r31_ext_rdata", 1, ext_rdata_w[1], 32'h55);
    step();

    // both requesting continuously: starvation grant, then cpu read right after
    set_cpu(1, 0, 32'h7, 0); set_ext(1, 0, 32'h5, 0);
    for (int i = 0; i < 6; i++) begin
      #2;
      check("r30_ext_grant", 0, ext_grant_w[0], (i == 4));
      check("r30_cpu_stall", 0, cpu_stall_w[0], (i == 4));
      check("r34_ext_grant", 1, ext_grant_w[1], (i % 2 == 1));
      if (i == 5) begin
        check("r32_ext_rvalid", 0, ext_rvalid_w[0], 32'h1);
        check("r32_ext_rdata", 0, ext_rdata_w[0], 32'hA500_0505);
        check("r30_cnt_after", 0, dbg_cnt_w[0], 32'h0);
      end
      step();
    end
    set_cpu(0, 0, 0, 0); set_ext(0, 0, 0, 0);
    #2;
    check("r32_cpu_rvalid", 0, cpu_rvalid_w[0], 32'h1);
    check("r32_cpu_rdata", 0, cpu_rdata_w[0], 32'hA500_0707);
    check("r32_ext_rvalid", 0, ext_rvalid_w[0], 32'h0);
    step();

    // reset right after a cpu read grant
    set_cpu(1, 0, 32'h3, 0); set_ext(1, 0, 32'h4, 0);
    step();
    rst = 1'b1;
    #2;
    check("r33_cpu_rvalid", 0, cpu_rvalid_w[0], 32'h0);
    check("r33_cpu_rdata", 0, cpu_rdata_w[0], 32'h0);
    check("r33_ext_grant", 0, ext_grant_w[0], 32'h0);
    check("r33_mem_we", 0, mem_we_w[0], 32'h0);
    check("r33_mem_idx", 0, mem_idx_w[0], 32'h0);
    check("r33_cpu_stall", 0, cpu_stall_w[0], 32'h1);
    step();
    rst = 1'b0;
    set_cpu(0, 0, 0, 0); set_ext(0, 0, 0, 0);
    #2;
    check("r33_cnt", 0, dbg_cnt_w[0], 32'h0);
    check("r33_cpu_rvalid_after", 0, cpu_rvalid_w[0], 32'h0);
    check("r33_state", 0, dbg_state_w[0], RD_IDLE);
    step();

    // randomized traffic; a waiting requester keeps its fields stable
    for (int n = 0; n < 3000; n++) begin
      if (!(cpu_req && !last_cpu_gnt)) begin
        set_cpu(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                32'($urandom_range(0, 15)), $urandom);
      end
      if (!(ext_req && !last_ext_gnt)) begin
        set_ext(($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                32'($urandom_range(0, 15)), $urandom);
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    set_cpu(0, 0, 0, 0); set_ext(0, 0, 0, 0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the number of consecutive denied ext cycles before ext is force-granted; legal range 1..15.
REQ-002 clk  input  Clock  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  input  Bool  SHALL be the synchronous, active-high reset.
REQ-004 cpu_req  input  Bool  SHALL be the pipeline memory-stage access request.
REQ-005 cpu_we  input  Bool  SHALL be the cpu write strobe, qualified by cpu_req.
REQ-006 cpu_addr / cpu_wdata  input  Data  SHALL be the cpu word index and store data.
REQ-007 cpu_stall  output  Bool  SHALL be high combinationally when cpu_req is high and cpu is not granted this cycle.
REQ-008 cpu_rvalid / cpu_rdata  output  Bool / Data  SHALL return cpu load data.
REQ-009 ext_req, ext_we  input  Bool; ext_addr, ext_wdata  input  Data  SHALL be the external (debug/DMA) request port.
REQ-010 ext_grant  output  Bool  SHALL be high combinationally in the cycle ext's access is issued.
REQ-011 ext_rvalid / ext_rdata  output  Bool / Data  SHALL return ext load data.
REQ-012 mem_idx, mem_write_data  output  Data; mem_write_enable  output  Bool; mem_read_data  input  Data  SHALL drive the single-port data memory.

Function
REQ-013 At most one access SHALL be issued per cycle; mem_idx/mem_write_data/mem_write_enable come combinationally from the granted requester.
REQ-014 With no grant, mem_write_enable SHALL be 0 and mem_idx/mem_write_data 0.
REQ-015 Priority: cpu SHALL win when both request, unless starve_cnt == STARVE_LIMIT, in which case ext wins.
REQ-016 starve_cnt (4-bit) SHALL increment on each cycle with ext_req high and ext not granted, saturate at STARVE_LIMIT, and clear on ext grant or ext_req low.
REQ-017 Memory read latency is one cycle: mem_read_data for an access issued in cycle N is valid in cycle N+1.
REQ-018 A read-return FSM SHALL track the in-flight read: states IDLE, CPU_RD, EXT_RD; next state = CPU_RD on cpu read grant, EXT_RD on ext read grant, else IDLE.
REQ-019 In CPU_RD, cpu_rvalid SHALL be 1 and cpu_rdata = mem_read_data; in EXT_RD likewise for ext; the other rvalid SHALL be 0, rdata registered at 0 otherwise.
REQ-020 Writes SHALL complete in the grant cycle and produce no rvalid.
REQ-021 Back-to-back reads from alternating owners SHALL be supported with no bubble; each returns to its own requester.
REQ-022 A requester SHALL hold its request fields stable while not granted; the arbiter SHALL not latch requests.
REQ-023 With STARVE_LIMIT = 1 and both requesting continuously, grants SHALL alternate cpu, ext, cpu, ext.

Reset
REQ-024 On rst high at a rising edge: FSM to IDLE, starve_cnt to 0, cpu_rvalid/ext_rvalid to 0, cpu_rdata/ext_rdata to 0.
REQ-025 A read in flight at reset SHALL be dropped (no rvalid in the following cycle).
REQ-026 While rst is high, no grant SHALL be issued: ext_grant 0, mem_write_enable 0, cpu_stall = cpu_req.

Structure
REQ-027 Owner enum (NONE, CPU, EXT), the read-FSM state typedef and the STARVE_LIMIT default SHALL live in the shared pipeline package.
REQ-028 No sub-module SHALL be instantiated; the DataMemory instance belongs to the parent, and the memory stage consumes cpu_stall.

Verification
REQ-029 cpu read addr 0x10 (mem holds 0xDEADBEEF), ext idle -> cpu_stall 0, next cycle cpu_rvalid 1, cpu_rdata 0xDEADBEEF, ext_rvalid 0.
REQ-030 Both request continuously, STARVE_LIMIT 4 -> cpu granted cycles 0..3, ext_grant and cpu_stall high in cycle 4, cpu granted in cycle 5, starve_cnt 0 after the ext grant.
REQ-031 cpu write 0x55 to 0x20 in cycle 0, ext read 0x20 in cycle 1 -> ext_rvalid in cycle 2 with ext_rdata 0x55.
REQ-032 Starvation grant of an ext read followed by a cpu read in the next cycle -> ext_rvalid then cpu_rvalid on consecutive cycles, correct data to each.
REQ-033 rst asserted in the cycle after a cpu read grant -> no cpu_rvalid, all outputs 0, starve_cnt 0.
REQ-034 STARVE_LIMIT 1, both requesting 6 cycles -> grants cpu, ext, cpu, ext, cpu, ext.
